// File: rtl/imem_loadable.sv
// Runtime-loadable instruction memory: clears itself to FILL after reset, accepts a
// program over a valid/ready loader port, then serves registered fetches with stall.
module imem_loadable #(
    parameter int            N     = 32,
    parameter int            DEPTH = 128,
    localparam int           AW    = $clog2(DEPTH),
    parameter logic [N-1:0]  FILL  = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_valid,
    input  logic [N-1:0]  ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    input  logic          rd_en,
    input  logic [AW-1:0] addr,
    output logic [N-1:0]  q,
    output logic          q_valid,
    output logic          busy,
    output logic [AW:0]   load_count
);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t        state_reg;
    state_t        state_next;
    logic [AW-1:0] clr_ptr_reg;
    logic [AW:0]   wr_ptr_reg;
    logic [N-1:0]  q_reg;
    logic          q_valid_reg;

    logic [N-1:0]  mem [DEPTH];

    logic          accept;
    logic          clr_done;
    logic          wr_at_end;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [N-1:0]  mem_wdata;
    logic          rd_fire;

    assign accept    = (state_reg == ST_LOAD) && ld_valid;
    assign clr_done  = (clr_ptr_reg == AW'(DEPTH - 1));
    assign wr_at_end = (wr_ptr_reg[AW-1:0] == AW'(DEPTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_CLEAR;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_CLEAR: if (clr_done) state_next = ST_LOAD;
            ST_LOAD:  if (accept && (ld_last || wr_at_end)) state_next = ST_RUN;
            ST_RUN:   state_next = ST_RUN;
            default:  state_next = ST_CLEAR;
        endcase
    end

    // Output / datapath control
    always_comb begin
        ld_ready  = 1'b0;
        busy      = 1'b1;
        mem_we    = 1'b0;
        mem_waddr = clr_ptr_reg;
        mem_wdata = FILL;
        rd_fire   = 1'b0;
        case (state_reg)
            ST_CLEAR: begin
                mem_we = ~reset;
            end
            ST_LOAD: begin
                ld_ready  = 1'b1;
                mem_we    = accept && ~reset;
                mem_waddr = wr_ptr_reg[AW-1:0];
                mem_wdata = ld_data;
            end
            ST_RUN: begin
                busy    = 1'b0;
                rd_fire = rd_en;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clr_ptr_reg <= '0;
            wr_ptr_reg  <= '0;
        end else begin
            if (state_reg == ST_CLEAR) begin
                clr_ptr_reg <= clr_ptr_reg + AW'(1);
            end
            if (accept) begin
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            end
        end
    end

    // Single write port shared by the clear sweep and the loader
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Synchronous read port; holds its value while stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            q_reg       <= FILL;
            q_valid_reg <= 1'b0;
        end else if (rd_fire) begin
            q_reg       <= mem[addr];
            q_valid_reg <= 1'b1;
        end
    end

    assign q          = q_reg;
    assign q_valid    = q_valid_reg;
    assign load_count = wr_ptr_reg;

endmodule
